branch_resolver: RTL and testbench

Branch resolution unit at the execute end of the global predictor. It keeps an in-order queue of branches that fetch has predicted, along with the branch history register (BHR) snapshot taken at prediction time. When execute reports a branch's real outcome, it compares that outcome against the oldest queued prediction. It then produces the registered pattern history table (PHT) update, the BHR repair value, the mispredict redirect and wrong-path flush, and performance counts.

---
 rtl/rv32i_types.sv | 10 +
 rtl/branch_queue.sv | 47 ++++
 rtl/branch_resolver.sv | 94 +++++++++
 tb/tb_branch_resolver.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// rv32i_types: shared types for the branch prediction/resolution path.
package rv32i_types;
    localparam int BQ_HIST_W = 4;
    typedef struct packed {
        logic [31:0]          pc;
        logic [BQ_HIST_W-1:0] bhr;
        logic                 taken;
        logic [31:0]          target;
    } bq_entry_t;
endpackage

// File: rtl/branch_queue.sv
// branch_queue: in-order FIFO of predicted branches with a one-cycle flush.
module branch_queue
    import rv32i_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  logic      pop,
    input  logic      clear,
    input  bq_entry_t push_data,
    output bq_entry_t head_data,
    output logic      full,
    output logic      empty
);
    localparam int PW = $clog2(DEPTH);
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;
    bq_entry_t     mem_q [DEPTH];
    assign full      = count_q == (PW+1)'(DEPTH);
    assign empty     = count_q == '0;
    assign head_data = mem_q[head_q];
    always_comb begin
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        head_d  = clear ? '0 : head_q + PW'(do_pop);
        tail_d  = clear ? '0 : tail_q + PW'(do_push);
        count_d = clear ? '0 : count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
    // Payload storage needs no reset: validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[tail_q] <= push_data;
    end
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: compares execute outcomes with queued predictions and emits
// registered PHT updates, BHR repair, mispredict redirect/flush and counters.
module branch_resolver
    import rv32i_types::*;
#(
    parameter int DEPTH  = 4,
    parameter int HIST_W = BQ_HIST_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pred_valid,
    input  logic [31:0]       pred_pc,
    input  logic [HIST_W-1:0] pred_bhr,
    input  logic              pred_taken,
    input  logic [31:0]       pred_target,
    output logic              pred_ready,
    input  logic              res_valid,
    input  logic              res_taken,
    input  logic [31:0]       res_target,
    output logic              res_ready,
    output logic              upd_valid,
    output logic [HIST_W-1:0] upd_index,
    output logic              upd_taken,
    output logic              mispredict,
    output logic [31:0]       redirect_pc,
    output logic [HIST_W-1:0] bhr_restore,
    output logic [31:0]       branch_count,
    output logic [31:0]       mispred_count
);
    bq_entry_t         head, new_entry;
    logic              q_full, q_empty, resolve, mis, push;
    logic              upd_valid_q, upd_valid_d, upd_taken_q, upd_taken_d;
    logic              mispredict_q, mispredict_d;
    logic [HIST_W-1:0] upd_index_q, upd_index_d, bhr_restore_q, bhr_restore_d;
    logic [31:0]       redirect_pc_q, redirect_pc_d;
    logic [31:0]       branch_count_q, branch_count_d, mispred_count_q, mispred_count_d;
    assign new_entry = '{pc: pred_pc, bhr: pred_bhr, taken: pred_taken, target: pred_target};
    branch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (resolve),
        .clear     (mis),
        .push_data (new_entry),
        .head_data (head),
        .full      (q_full),
        .empty     (q_empty)
    );
    // A mispredict flushes the queue, so a same-cycle enqueue is wrong-path and dropped.
    always_comb begin
        resolve         = res_valid & ~q_empty;
        mis             = resolve & ((res_taken != head.taken) | (res_taken & (res_target != head.target)));
        push            = pred_valid & ~q_full & ~mis;
        upd_valid_d     = resolve;
        mispredict_d    = mis;
        upd_index_d     = resolve ? head.bhr ^ head.pc[HIST_W+1:2] : upd_index_q;
        upd_taken_d     = resolve ? res_taken : upd_taken_q;
        redirect_pc_d   = resolve ? (res_taken ? res_target : head.pc + 32'd4) : redirect_pc_q;
        bhr_restore_d   = resolve ? {head.bhr[HIST_W-2:0], res_taken} : bhr_restore_q;
        branch_count_d  = branch_count_q + 32'(resolve);
        mispred_count_d = mispred_count_q + 32'(mis);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_valid_q     <= 1'b0;
            upd_index_q     <= '0;
            upd_taken_q     <= 1'b0;
            mispredict_q    <= 1'b0;
            redirect_pc_q   <= '0;
            bhr_restore_q   <= '0;
            branch_count_q  <= '0;
            mispred_count_q <= '0;
        end else begin
            upd_valid_q     <= upd_valid_d;
            upd_index_q     <= upd_index_d;
            upd_taken_q     <= upd_taken_d;
            mispredict_q    <= mispredict_d;
            redirect_pc_q   <= redirect_pc_d;
            bhr_restore_q   <= bhr_restore_d;
            branch_count_q  <= branch_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end
    assign pred_ready    = ~q_full;
    assign res_ready     = ~q_empty;
    assign upd_valid     = upd_valid_q;
    assign upd_index     = upd_index_q;
    assign upd_taken     = upd_taken_q;
    assign mispredict    = mispredict_q;
    assign redirect_pc   = redirect_pc_q;
    assign bhr_restore   = bhr_restore_q;
    assign branch_count  = branch_count_q;
    assign mispred_count = mispred_count_q;
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: table-driven directed vectors plus reset corner sequences.
module tb_branch_resolver;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        pred_valid = 0, pred_taken = 0, res_valid = 0, res_taken = 0;
    logic [31:0] pred_pc = 0, pred_target = 0, res_target = 0;
    logic [3:0]  pred_bhr = 0;
    logic        pred_ready, res_ready, upd_valid, upd_taken, mispredict;
    logic [3:0]  upd_index, bhr_restore;
    logic [31:0] redirect_pc, branch_count, mispred_count;
    int          n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;

    branch_resolver #(.DEPTH(4), .HIST_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_bhr(pred_bhr),
        .pred_taken(pred_taken), .pred_target(pred_target), .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .res_ready(res_ready), .upd_valid(upd_valid), .upd_index(upd_index),
        .upd_taken(upd_taken), .mispredict(mispredict), .redirect_pc(redirect_pc),
        .bhr_restore(bhr_restore), .branch_count(branch_count), .mispred_count(mispred_count)
    );

    typedef struct {
        logic pv; logic [31:0] pc; logic [3:0] bhr; logic pt; logic [31:0] ptgt;
        logic rv; logic rt; logic [31:0] rtgt;
        logic e_pr; logic e_rr; logic e_uv; logic [3:0] e_idx; logic e_ut; logic e_mis;
        logic [31:0] e_rpc; logic [3:0] e_rst; logic [31:0] e_bc; logic [31:0] e_mc;
    } vec_t;
    vec_t vecs [23];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [31:0] pc, input logic [3:0] bhr,
                         input logic pt, input logic [31:0] ptgt,
                         input logic rv, input logic rt, input logic [31:0] rtgt);
        pred_valid = pv; pred_pc = pc; pred_bhr = bhr; pred_taken = pt; pred_target = ptgt;
        res_valid = rv; res_taken = rt; res_target = rtgt;
    endtask

    initial begin
        //          pv pc       bhr   pt ptgt     rv rt rtgt      pr rr uv idx   ut mis rpc      rst   bc mc
        vecs[0]  = '{0, 32'h0,   4'h0, 0, 32'h0,   1, 1, 32'h40,  1, 0, 0, 4'h0, 0, 0, 32'h0,   4'h0, 0, 0};
        vecs[1]  = '{1, 32'h100, 4'ha, 0, 32'h0,   0, 0, 32'h0,   1, 1, 0, 4'h0, 0, 0, 32'h0,   4'h0, 0, 0};
        vecs[2]  = '{0, 32'h0,   4'h0, 0, 32'h0,   1, 0, 32'h0,   1, 0, 1, 4'ha, 0, 0, 32'h0,   4'h0, 1, 0};
        vecs[3]  = '{1, 32'h204, 4'h3, 0, 32'h0,   0, 0, 32'h0,   1, 1, 0, 4'h0, 0, 0, 32'h0,   4'h0, 1, 0};
        vecs[4]  = '{1, 32'h300, 4'h0, 0, 32'h0,   0, 0, 32'h0,   1, 1, 0, 4'h0, 0, 0, 32'h0,   4'h0, 1, 0};
        vecs[5]  = '{1, 32'h304, 4'h0, 0, 32'h0,   0, 0, 32'h0,   1, 1, 0, 4'h0, 0, 0, 32'h0,   4'h0, 1, 0};
        vecs[6]  = '{0, 32'h0,   4'h0, 0, 32'h0,   1, 1, 32'h400, 1, 0, 1, 4'h2, 1, 1, 32'h400, 4'h7, 2, 1};
        vecs[7]  = '{0, 32'h0,   4'h0, 0, 32'h0,   0, 0, 32'h0,   1, 0, 0, 4'h0, 0, 0, 32'h0,   4'h0, 2, 1};
        vecs[8]  = '{1, 32'h440, 4'h5, 1, 32'h500, 0, 0, 32'h0,   1, 1, 0, 4'h0, 0, 0, 32'h0,   4'h0, 2, 1};
        vecs[9]  = '{0, 32'h0,   4'h0, 0, 32'h0,   1, 1, 32'h540, 1, 0, 1, 4'h5, 1, 1, 32'h540, 4'hb, 3, 2};
        vecs[10] = '{1, 32'h600, 4'h0, 0, 32'h0,   0, 0, 32'h0,   1, 1, 0, 4'h0, 0, 0, 32'h0,   4'h0, 3, 2};
        vecs[11] = '{1, 32'h604, 4'h0, 0, 32'h0,   1, 1, 32'h700, 1, 0, 1, 4'h0, 1, 1, 32'h700, 4'h1, 4, 3};
        vecs[12] = '{1, 32'h800, 4'h1, 0, 32'h0,   0, 0, 32'h0,   1, 1, 0, 4'h0, 0, 0, 32'h0,   4'h0, 4, 3};
        vecs[13] = '{1, 32'h804, 4'h2, 0, 32'h0,   0, 0, 32'h0,   1, 1, 0, 4'h0, 0, 0, 32'h0,   4'h0, 4, 3};
        vecs[14] = '{1, 32'h808, 4'h3, 0, 32'h0,   0, 0, 32'h0,   1, 1, 0, 4'h0, 0, 0, 32'h0,   4'h0, 4, 3};
        vecs[15] = '{1, 32'h80c, 4'h4, 0, 32'h0,   0, 0, 32'h0,   0, 1, 0, 4'h0, 0, 0, 32'h0,   4'h0, 4, 3};
        vecs[16] = '{1, 32'h900, 4'h9, 0, 32'h0,   0, 0, 32'h0,   0, 1, 0, 4'h0, 0, 0, 32'h0,   4'h0, 4, 3};
        vecs[17] = '{1, 32'h900, 4'h9, 0, 32'h0,   1, 0, 32'h0,   1, 1, 1, 4'h1, 0, 0, 32'h0,   4'h0, 5, 3};
        vecs[18] = '{1, 32'h810, 4'h5, 0, 32'h0,   1, 0, 32'h0,   1, 1, 1, 4'h3, 0, 0, 32'h0,   4'h0, 6, 3};
        vecs[19] = '{0, 32'h0,   4'h0, 0, 32'h0,   1, 0, 32'h0,   1, 1, 1, 4'h1, 0, 0, 32'h0,   4'h0, 7, 3};
        vecs[20] = '{0, 32'h0,   4'h0, 0, 32'h0,   1, 0, 32'h0,   1, 1, 1, 4'h7, 0, 0, 32'h0,   4'h0, 8, 3};
        vecs[21] = '{0, 32'h0,   4'h0, 0, 32'h0,   1, 0, 32'h0,   1, 0, 1, 4'h1, 0, 0, 32'h0,   4'h0, 9, 3};
        vecs[22] = '{0, 32'h0,   4'h0, 0, 32'h0,   1, 1, 32'h0,   1, 0, 0, 4'h0, 0, 0, 32'h0,   4'h0, 9, 3};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_pred_ready", 32'(pred_ready), 1);
        chk("rst_res_ready", 32'(res_ready), 0);
        chk("rst_upd_valid", 32'(upd_valid), 0);
        chk("rst_mispredict", 32'(mispredict), 0);
        chk("rst_upd_index", 32'(upd_index), 0);
        chk("rst_upd_taken", 32'(upd_taken), 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_bhr_restore", 32'(bhr_restore), 0);
        chk("rst_branch_count", branch_count, 0);
        chk("rst_mispred_count", mispred_count, 0);

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            drive(vecs[i].pv, vecs[i].pc, vecs[i].bhr, vecs[i].pt, vecs[i].ptgt,
                  vecs[i].rv, vecs[i].rt, vecs[i].rtgt);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pred_ready", i), 32'(pred_ready), 32'(vecs[i].e_pr));
            chk($sformatf("v%0d_res_ready", i), 32'(res_ready), 32'(vecs[i].e_rr));
            chk($sformatf("v%0d_upd_valid", i), 32'(upd_valid), 32'(vecs[i].e_uv));
            chk($sformatf("v%0d_mispredict", i), 32'(mispredict), 32'(vecs[i].e_mis));
            chk($sformatf("v%0d_branch_count", i), branch_count, vecs[i].e_bc);
            chk($sformatf("v%0d_mispred_count", i), mispred_count, vecs[i].e_mc);
            if (vecs[i].e_uv) begin
                chk($sformatf("v%0d_upd_index", i), 32'(upd_index), 32'(vecs[i].e_idx));
                chk($sformatf("v%0d_upd_taken", i), 32'(upd_taken), 32'(vecs[i].e_ut));
            end
            if (vecs[i].e_mis) begin
                chk($sformatf("v%0d_redirect_pc", i), redirect_pc, vecs[i].e_rpc);
                chk($sformatf("v%0d_bhr_restore", i), 32'(bhr_restore), 32'(vecs[i].e_rst));
            end
        end

        // Reset with three entries in flight and a mispredicting resolve presented.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1, 32'ha00 + 32'(4 * i), 4'h6, 0, 32'h0, 0, 0, 32'h0);
        end
        @(negedge clk);
        drive(0, 32'h0, 4'h0, 0, 32'h0, 1, 1, 32'hb00);
        chk("mid_res_ready_before", 32'(res_ready), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_res_ready", 32'(res_ready), 0);
        chk("mid_rst_pred_ready", 32'(pred_ready), 1);
        chk("mid_rst_branch_count", branch_count, 0);
        chk("mid_rst_mispred_count", mispred_count, 0);
        @(posedge clk);
        #1;
        chk("mid_rst_no_mispredict", 32'(mispredict), 0);
        chk("mid_rst_no_upd_valid", 32'(upd_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_empty_no_upd", 32'(upd_valid), 0);

        // Reset while a registered mispredict strobe is pending.
        @(negedge clk);
        drive(1, 32'hc00, 4'h2, 0, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        drive(0, 32'h0, 4'h0, 0, 32'h0, 1, 1, 32'hd00);
        @(posedge clk);
        #1;
        chk("pend_mispredict", 32'(mispredict), 1);
        chk("pend_redirect_pc", redirect_pc, 32'hd00);
        rst_n = 1'b0;
        #1;
        chk("pend_rst_mispredict", 32'(mispredict), 0);
        chk("pend_rst_upd_valid", 32'(upd_valid), 0);
        chk("pend_rst_redirect_pc", redirect_pc, 0);
        chk("pend_rst_mispred_count", mispred_count, 0);
        drive(0, 32'h0, 4'h0, 0, 32'h0, 0, 0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
